// File: rtl/ctrl_mem_datos.sv
// ---------------------------------------------------------------------------
// ctrl_mem_datos
//
// Load/store access controller placed between the MEM-stage pipeline logic
// and the Mem_datos data memory. It takes one valid/ready request at a time,
// rejects misaligned or unmapped addresses without touching the memory, and
// for legal requests drives the active-low Mem_rd/Mem_wr strobe for exactly
// one cycle. Load data is captured from the memory's registered output and
// every request is answered with a single-cycle response pulse.
//
// Ports:
//   clk           system clock, all state on rising edge
//   rst_n         asynchronous active-low reset
//   req_valid     request present
//   req_ready     controller can accept (high only in IDLE)
//   req_wr        1 = store, 0 = load
//   req_dir       byte address of the request
//   req_dato      store data
//   resp_valid    one-cycle response pulse
//   resp_err      qualifies resp_valid; 1 = misaligned or unmapped address
//   resp_dato     load data; holds its last value otherwise
//   Mem_rd        active-low read strobe to memory
//   Mem_wr        active-low write strobe to memory
//   Dir_Mem       address to memory
//   Dato_Mem_in   write data to memory
//   Dato_Mem_out  registered read data from memory
// ---------------------------------------------------------------------------
module ctrl_mem_datos #(
    parameter int unsigned      ANCHO   = 32,
    parameter logic [ANCHO-1:0] BASE    = 32'h10000000,
    parameter int unsigned      NUM_PAL = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_wr,
    input  logic [ANCHO-1:0] req_dir,
    input  logic [ANCHO-1:0] req_dato,
    output logic             resp_valid,
    output logic             resp_err,
    output logic [ANCHO-1:0] resp_dato,
    output logic             Mem_rd,
    output logic             Mem_wr,
    output logic [ANCHO-1:0] Dir_Mem,
    output logic [ANCHO-1:0] Dato_Mem_in,
    input  logic [ANCHO-1:0] Dato_Mem_out
);

    // Byte address of the last mapped word; the range check is inclusive.
    localparam logic [ANCHO-1:0] ULTIMA = BASE + ANCHO'(4 * (NUM_PAL - 1));

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        ESP,
        RESP
    } estado_t;

    estado_t          estado;
    estado_t          estado_sig;
    logic             es_wr;
    logic             es_wr_sig;
    logic             rd_sig;
    logic             wr_sig;
    logic [ANCHO-1:0] dir_sig;
    logic [ANCHO-1:0] din_sig;
    logic             rv_sig;
    logic             re_sig;
    logic [ANCHO-1:0] rdato_sig;
    logic             dir_alineada;
    logic             dir_en_rango;
    logic             dir_legal;

    // Unsigned full-width compare, so addresses below BASE (including the
    // wrap-around region) and above the last word are both rejected.
    assign dir_alineada = (req_dir[1:0] == 2'b00);
    assign dir_en_rango = (req_dir >= BASE) && (req_dir <= ULTIMA);
    assign dir_legal    = dir_alineada && dir_en_rango;

    // Only IDLE accepts work; anything offered in other states is ignored
    // and must be held by the requester.
    assign req_ready = (estado == IDLE);

    // Next-state and next-output logic. Strobes default to inactive so they
    // can only be low in the cycle right after a legal accept (the ACC
    // cycle), which also guarantees they are never low together. Address
    // and write data default to holding so the memory sees stable values
    // through the access.
    always_comb begin
        estado_sig = estado;
        es_wr_sig  = es_wr;
        rd_sig     = 1'b1;
        wr_sig     = 1'b1;
        dir_sig    = Dir_Mem;
        din_sig    = Dato_Mem_in;
        rv_sig     = 1'b0;
        re_sig     = 1'b0;
        rdato_sig  = resp_dato;

        case (estado)
            IDLE: begin
                if (req_valid) begin
                    if (dir_legal) begin
                        estado_sig = ACC;
                        es_wr_sig  = req_wr;
                        dir_sig    = req_dir;
                        din_sig    = req_dato;
                        if (req_wr) begin
                            wr_sig = 1'b0;
                        end else begin
                            rd_sig = 1'b0;
                        end
                    end else begin
                        estado_sig = RESP;
                        rv_sig     = 1'b1;
                        re_sig     = 1'b1;
                    end
                end
            end
            ACC: begin
                estado_sig = ESP;
            end
            ESP: begin
                if (!es_wr) begin
                    rdato_sig = Dato_Mem_out;
                end
                rv_sig     = 1'b1;
                estado_sig = RESP;
            end
            RESP: begin
                estado_sig = IDLE;
            end
            default: begin
                estado_sig = IDLE;
            end
        endcase
    end

    // State and registered outputs. Reset is asynchronous so an access in
    // flight is aborted immediately: strobes go high without waiting for an
    // edge and no response is produced.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado      <= IDLE;
            es_wr       <= 1'b0;
            Mem_rd      <= 1'b1;
            Mem_wr      <= 1'b1;
            Dir_Mem     <= '0;
            Dato_Mem_in <= '0;
            resp_valid  <= 1'b0;
            resp_err    <= 1'b0;
            resp_dato   <= '0;
        end else begin
            estado      <= estado_sig;
            es_wr       <= es_wr_sig;
            Mem_rd      <= rd_sig;
            Mem_wr      <= wr_sig;
            Dir_Mem     <= dir_sig;
            Dato_Mem_in <= din_sig;
            resp_valid  <= rv_sig;
            resp_err    <= re_sig;
            resp_dato   <= rdato_sig;
        end
    end

endmodule

// File: tb/tb_ctrl_mem_datos.sv
// ---------------------------------------------------------------------------
// tb_ctrl_mem_datos
//
// Testbench for ctrl_mem_datos with a Mem_datos-like memory attached. The
// memory powers up with 0x0000000A, 0x0BE12120, 0x00000001, writes on an
// active-low Mem_wr edge and registers read data on an active-low Mem_rd
// edge. Expected responses come from a word-array reference model of the
// mapped memory plus the last returned load value.
// ---------------------------------------------------------------------------
module tb_ctrl_mem_datos;

    localparam logic [31:0] BASE    = 32'h10000000;
    localparam int          NUM_PAL = 3;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_wr;
    logic [31:0] req_dir;
    logic [31:0] req_dato;
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] resp_dato;
    logic        Mem_rd;
    logic        Mem_wr;
    logic [31:0] Dir_Mem;
    logic [31:0] Dato_Mem_in;
    logic [31:0] Dato_Mem_out;

    int          n_checks;
    int          n_fail;

    logic [31:0] mem [0:NUM_PAL-1];
    logic [31:0] ref_mem [0:NUM_PAL-1];
    logic [31:0] last_dato;

    ctrl_mem_datos #(
        .ANCHO   (32),
        .BASE    (BASE),
        .NUM_PAL (NUM_PAL)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_wr       (req_wr),
        .req_dir      (req_dir),
        .req_dato     (req_dato),
        .resp_valid   (resp_valid),
        .resp_err     (resp_err),
        .resp_dato    (resp_dato),
        .Mem_rd       (Mem_rd),
        .Mem_wr       (Mem_wr),
        .Dir_Mem      (Dir_Mem),
        .Dato_Mem_in  (Dato_Mem_in),
        .Dato_Mem_out (Dato_Mem_out)
    );

    // 10 ns clock; inputs are driven and outputs sampled on the falling edge.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Attached data memory. Its contents survive controller resets, the way
    // the real memory does.
    initial begin
        mem[0]       = 32'h0000000A;
        mem[1]       = 32'h0BE12120;
        mem[2]       = 32'h00000001;
        Dato_Mem_out = 32'h0;
    end

    always @(posedge clk) begin
        if (!Mem_wr && ((Dir_Mem - BASE) >> 2) < NUM_PAL) begin
            mem[(Dir_Mem - BASE) >> 2] <= Dato_Mem_in;
        end
        if (!Mem_rd && ((Dir_Mem - BASE) >> 2) < NUM_PAL) begin
            Dato_Mem_out <= mem[(Dir_Mem - BASE) >> 2];
        end
    end

    // Strobe exclusivity is checked on every cycle of every scenario.
    always @(negedge clk) begin
        if (rst_n) begin
            n_checks++;
            if (!Mem_rd && !Mem_wr) begin
                n_fail++;
                $display("[TB] FAIL strobe_exclusive: Mem_rd=%b Mem_wr=%b, required not both 0", Mem_rd, Mem_wr);
            end
        end
    end

    // Watchdog so the bench always ends even if the DUT stalls completely.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Presents one request, waits (bounded) for acceptance, then observes a
    // four-cycle window after the accepting edge. Window index 0 is the
    // cycle right after the accept edge.
    task automatic applyStimulus(input logic wr, input logic [31:0] dir, input logic [31:0] dato,
                                 output bit ok, output int rd_lo, output int wr_lo,
                                 output int lat, output int nresp, output logic err,
                                 output logic [31:0] rdato, output logic [31:0] dir_seen,
                                 output logic [31:0] wdato_seen);
        int w;
        ok         = 1'b0;
        rd_lo      = 0;
        wr_lo      = 0;
        lat        = -1;
        nresp      = 0;
        err        = 1'b0;
        rdato      = resp_dato;
        dir_seen   = 32'h0;
        wdato_seen = 32'h0;
        @(negedge clk);
        w = 0;
        while (!req_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (!req_ready) return;
        req_valid = 1'b1;
        req_wr    = wr;
        req_dir   = dir;
        req_dato  = dato;
        @(posedge clk);
        ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 0) begin
                req_valid = 1'b0;
                req_wr    = 1'($urandom);
                req_dir   = $urandom;
                req_dato  = $urandom;
            end
            if (!Mem_rd) begin
                rd_lo++;
                dir_seen = Dir_Mem;
            end
            if (!Mem_wr) begin
                wr_lo++;
                dir_seen   = Dir_Mem;
                wdato_seen = Dato_Mem_in;
            end
            if (resp_valid) begin
                nresp++;
                if (lat < 0) lat = i;
                err   = resp_err;
                rdato = resp_dato;
            end
        end
    endtask

    // Reset values, checked while reset is held.
    task automatic test_reset();
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_wr    = 1'b0;
        req_dir   = 32'h0;
        req_dato  = 32'h0;
        #23;
        n_checks++;
        if (Mem_rd !== 1'b1 || Mem_wr !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL reset_strobes: Mem_rd=%b Mem_wr=%b, required 1 1", Mem_rd, Mem_wr);
        end
        n_checks++;
        if (Dir_Mem !== 32'h0 || Dato_Mem_in !== 32'h0) begin
            n_fail++;
            $display("[TB] FAIL reset_mem_bus: Dir_Mem=%h Dato_Mem_in=%h, required 0 0", Dir_Mem, Dato_Mem_in);
        end
        n_checks++;
        if (resp_valid !== 1'b0 || resp_err !== 1'b0 || resp_dato !== 32'h0) begin
            n_fail++;
            $display("[TB] FAIL reset_resp: valid=%b err=%b dato=%h, required 0 0 0", resp_valid, resp_err, resp_dato);
        end
        n_checks++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL reset_ready: got %b, required 1", req_ready);
        end
        @(negedge clk);
        rst_n     = 1'b1;
        last_dato = 32'h0;
    endtask

    // Plain load of word 0.
    task automatic test_load_base();
        bit ok; int rd_lo, wr_lo, lat, nresp; logic err; logic [31:0] rdato, dseen, wseen;
        applyStimulus(1'b0, BASE, $urandom, ok, rd_lo, wr_lo, lat, nresp, err, rdato, dseen, wseen);
        n_checks++;
        if (!ok || rd_lo != 1 || wr_lo != 0 || dseen !== BASE) begin
            n_fail++;
            $display("[TB] FAIL load_base_strobe: ok=%0d rd_low=%0d wr_low=%0d dir=%h, required 1 1 0 %h", ok, rd_lo, wr_lo, dseen, BASE);
        end
        n_checks++;
        if (lat != 2 || nresp != 1 || err !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL load_base_resp: lat=%0d n=%0d err=%b, required 2 1 0", lat, nresp, err);
        end
        n_checks++;
        if (rdato !== ref_mem[0]) begin
            n_fail++;
            $display("[TB] FAIL load_base_data: got %h, required %h", rdato, ref_mem[0]);
        end
        last_dato = ref_mem[0];
    endtask

    // Store to the last word, then read it back.
    task automatic test_store_load();
        bit ok; int rd_lo, wr_lo, lat, nresp; logic err; logic [31:0] rdato, dseen, wseen;
        applyStimulus(1'b1, BASE + 32'h8, 32'hDEADBEEF, ok, rd_lo, wr_lo, lat, nresp, err, rdato, dseen, wseen);
        n_checks++;
        if (!ok || wr_lo != 1 || rd_lo != 0 || wseen !== 32'hDEADBEEF || dseen !== BASE + 32'h8) begin
            n_fail++;
            $display("[TB] FAIL store_strobe: ok=%0d wr_low=%0d rd_low=%0d data=%h dir=%h, required 1 1 0 deadbeef 10000008", ok, wr_lo, rd_lo, wseen, dseen);
        end
        n_checks++;
        if (lat != 2 || nresp != 1 || err !== 1'b0 || rdato !== last_dato) begin
            n_fail++;
            $display("[TB] FAIL store_resp: lat=%0d n=%0d err=%b dato=%h, required 2 1 0 %h", lat, nresp, err, rdato, last_dato);
        end
        ref_mem[2] = 32'hDEADBEEF;
        applyStimulus(1'b0, BASE + 32'h8, $urandom, ok, rd_lo, wr_lo, lat, nresp, err, rdato, dseen, wseen);
        n_checks++;
        if (!ok || rdato !== 32'hDEADBEEF || err !== 1'b0 || lat != 2) begin
            n_fail++;
            $display("[TB] FAIL store_readback: ok=%0d dato=%h err=%b lat=%0d, required 1 deadbeef 0 2", ok, rdato, err, lat);
        end
        last_dato = 32'hDEADBEEF;
    endtask

    // Misaligned and unmapped addresses, including both neighbours of the
    // mapped window; a rejected store must not alter memory.
    task automatic test_illegal();
        logic [31:0] dirs [4];
        logic        wrs  [4];
        bit ok; int rd_lo, wr_lo, lat, nresp; logic err; logic [31:0] rdato, dseen, wseen;
        dirs[0] = BASE + 32'h6;  wrs[0] = 1'b0;
        dirs[1] = BASE + 32'hC;  wrs[1] = 1'b0;
        dirs[2] = BASE - 32'h4;  wrs[2] = 1'b1;
        dirs[3] = BASE + 32'hC;  wrs[3] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(wrs[i], dirs[i], $urandom, ok, rd_lo, wr_lo, lat, nresp, err, rdato, dseen, wseen);
            n_checks++;
            if (!ok || rd_lo != 0 || wr_lo != 0) begin
                n_fail++;
                $display("[TB] FAIL illegal_no_strobe dir=%h: ok=%0d rd_low=%0d wr_low=%0d, required 1 0 0", dirs[i], ok, rd_lo, wr_lo);
            end
            n_checks++;
            if (lat != 0 || nresp != 1 || err !== 1'b1 || rdato !== last_dato) begin
                n_fail++;
                $display("[TB] FAIL illegal_resp dir=%h: lat=%0d n=%0d err=%b dato=%h, required 0 1 1 %h", dirs[i], lat, nresp, err, rdato, last_dato);
            end
        end
    endtask

    // Two loads with req_valid held high; responses in order, one per request.
    task automatic test_back_to_back();
        int          acc [$];
        logic [31:0] got [$];
        int          ready_low;
        int          nerr;
        bit          pend;
        ready_low = 0;
        nerr      = 0;
        pend      = 1'b0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (i == 0) begin
                req_valid = 1'b1;
                req_wr    = 1'b0;
                req_dir   = BASE + 32'h4;
                req_dato  = $urandom;
            end
            if (resp_valid) begin
                got.push_back(resp_dato);
                if (resp_err) nerr++;
            end
            if (pend) begin
                pend = 1'b0;
                if (acc.size() == 1) req_dir = BASE;
                else req_valid = 1'b0;
            end
            if (acc.size() == 1 && !req_ready) ready_low++;
            if (req_valid && req_ready) begin
                acc.push_back(i);
                pend = 1'b1;
            end
        end
        req_valid = 1'b0;
        n_checks++;
        if (acc.size() != 2) begin
            n_fail++;
            $display("[TB] FAIL b2b_accepts: got %0d accepts, required 2", acc.size());
        end else begin
            n_checks++;
            if (acc[1] - acc[0] != 4 || ready_low != 3) begin
                n_fail++;
                $display("[TB] FAIL b2b_spacing: gap=%0d ready_low=%0d, required 4 3", acc[1] - acc[0], ready_low);
            end
        end
        n_checks++;
        if (got.size() != 2 || nerr != 0) begin
            n_fail++;
            $display("[TB] FAIL b2b_resp_count: got %0d responses %0d errors, required 2 0", got.size(), nerr);
        end else begin
            n_checks++;
            if (got[0] !== ref_mem[1] || got[1] !== ref_mem[0]) begin
                n_fail++;
                $display("[TB] FAIL b2b_order: got %h %h, required %h %h", got[0], got[1], ref_mem[1], ref_mem[0]);
            end
        end
        last_dato = ref_mem[0];
    endtask

    // Reset asserted while a load strobe is active aborts it with no edge.
    task automatic test_reset_abort();
        bit ok; int rd_lo, wr_lo, lat, nresp; logic err; logic [31:0] rdato, dseen, wseen;
        int w;
        int seen_resp;
        @(negedge clk);
        w = 0;
        while (!req_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        req_valid = 1'b1;
        req_wr    = 1'b0;
        req_dir   = BASE + 32'h8;
        @(posedge clk);
        #2;
        n_checks++;
        if (Mem_rd !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL abort_strobe_active: Mem_rd=%b, required 0", Mem_rd);
        end
        rst_n     = 1'b0;
        req_valid = 1'b0;
        #1;
        n_checks++;
        if (Mem_rd !== 1'b1 || Mem_wr !== 1'b1 || resp_valid !== 1'b0 || resp_dato !== 32'h0) begin
            n_fail++;
            $display("[TB] FAIL abort_async: Mem_rd=%b Mem_wr=%b valid=%b dato=%h, required 1 1 0 0", Mem_rd, Mem_wr, resp_valid, resp_dato);
        end
        seen_resp = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i == 2) rst_n = 1'b1;
            if (resp_valid || !Mem_rd) seen_resp++;
        end
        n_checks++;
        if (seen_resp != 0) begin
            n_fail++;
            $display("[TB] FAIL abort_no_resp: %0d cycles with response or strobe, required 0", seen_resp);
        end
        last_dato = 32'h0;
        applyStimulus(1'b0, BASE + 32'h4, $urandom, ok, rd_lo, wr_lo, lat, nresp, err, rdato, dseen, wseen);
        n_checks++;
        if (!ok || rdato !== ref_mem[1] || err !== 1'b0 || lat != 2) begin
            n_fail++;
            $display("[TB] FAIL abort_reload: ok=%0d dato=%h err=%b lat=%0d, required 1 %h 0 2", ok, rdato, err, lat, ref_mem[1]);
        end
        last_dato = ref_mem[1];
    endtask

    // Random loads/stores over mapped, neighbouring, misaligned and wild
    // addresses, checked against the word-array model.
    task automatic test_random();
        bit ok; int rd_lo, wr_lo, lat, nresp; logic err; logic [31:0] rdato, dseen, wseen;
        logic [31:0] dir, dato;
        logic        wr;
        bit          legal;
        int          idx;
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 6))
                0: dir = BASE - 32'h4;
                1: dir = BASE + 32'(4 * NUM_PAL);
                2: dir = BASE + 32'($urandom_range(0, 4 * NUM_PAL - 1));
                3: dir = $urandom;
                default: dir = BASE + 32'(4 * $urandom_range(0, NUM_PAL - 1));
            endcase
            wr    = 1'($urandom);
            dato  = $urandom;
            legal = (dir % 4 == 0) && (longint'(dir) >= longint'(BASE))
                    && (longint'(dir) < longint'(BASE) + 4 * NUM_PAL);
            idx   = legal ? int'((dir - BASE) / 4) : 0;
            applyStimulus(wr, dir, dato, ok, rd_lo, wr_lo, lat, nresp, err, rdato, dseen, wseen);
            n_checks++;
            if (!ok || nresp != 1 || err !== !legal || lat != (legal ? 2 : 0)) begin
                n_fail++;
                $display("[TB] FAIL rand_resp #%0d dir=%h wr=%b: ok=%0d n=%0d err=%b lat=%0d, required 1 1 %b %0d", n, dir, wr, ok, nresp, err, lat, !legal, legal ? 2 : 0);
            end
            n_checks++;
            if (rd_lo != ((legal && !wr) ? 1 : 0) || wr_lo != ((legal && wr) ? 1 : 0)) begin
                n_fail++;
                $display("[TB] FAIL rand_strobe #%0d dir=%h wr=%b: rd_low=%0d wr_low=%0d, required %0d %0d", n, dir, wr, rd_lo, wr_lo, (legal && !wr) ? 1 : 0, (legal && wr) ? 1 : 0);
            end
            if (legal && wr) begin
                ref_mem[idx] = dato;
            end else if (legal) begin
                last_dato = ref_mem[idx];
            end
            n_checks++;
            if (rdato !== last_dato) begin
                n_fail++;
                $display("[TB] FAIL rand_data #%0d dir=%h wr=%b: got %h, required %h", n, dir, wr, rdato, last_dato);
            end
        end
    endtask

    // Test sequence and summary.
    initial begin
        n_checks   = 0;
        n_fail     = 0;
        ref_mem[0] = 32'h0000000A;
        ref_mem[1] = 32'h0BE12120;
        ref_mem[2] = 32'h00000001;
        last_dato  = 32'h0;
        test_reset();
        test_load_base();
        test_store_load();
        test_illegal();
        test_back_to_back();
        test_reset_abort();
        test_random();
        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
